// File: rtl/ex_alu_unit.sv
// EX-stage ALU with a registered result and flag. Optional iterative shift-add multiplier,
// enabled with EX_ALU_MUL_EN; without it, code 0101 completes in one cycle with result 0.
module ex_alu_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        valid_o,
  output logic        busy_o
);

  localparam logic [3:0] CtrlMul = 4'b0101;

  logic [31:0] alu_res;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;

  // Single-cycle operations; MUL is produced by the iterative path.
  always_comb begin
    alu_res = '0;
    case (ctrl_i)
      4'b0000: alu_res = data1_i & data2_i;
      4'b0001: alu_res = data1_i ^ data2_i;
      4'b0010: alu_res = data1_i << data2_i[4:0];
      4'b0011: alu_res = data1_i + data2_i;
      4'b0100: alu_res = data1_i - data2_i;
      4'b0110: alu_res = data1_i + data2_i;
      4'b0111: alu_res = $unsigned($signed(data1_i) >>> data2_i[4:0]);
      4'b1000: alu_res = data1_i + data2_i;
      4'b1001: alu_res = data1_i - data2_i;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_ALU_MUL_EN
  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] step_acc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    step_acc = acc_q + (opb_q[cnt_q] ? (opa_q << cnt_q) : 32'd0);

    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (ctrl_i == CtrlMul) begin
              opa_d   = data1_i;
              opb_d   = data2_i;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StMul;
            end else begin
              result_d = alu_res;
              zero_d   = (alu_res == 32'd0);
              valid_d  = 1'b1;
            end
          end
        end
        StMul: begin
          acc_d = step_acc;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = step_acc;
            zero_d   = (step_acc == 32'd0);
            valid_d  = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o = (state_q == StMul);
`else
  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    valid_d  = 1'b0;
    if (start_i && !flush_i) begin
      result_d = alu_res;
      zero_d   = (alu_res == 32'd0);
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o = 1'b0;
`endif

  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign valid_o  = valid_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed self-checking bench for ex_alu_unit; MUL scenarios run when EX_ALU_MUL_EN is defined.
module tb_ex_alu_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [3:0]  ctrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        valid_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  ex_alu_unit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ctrl_i   (ctrl_i),
    .data1_i  (data1_i),
    .data2_i  (data2_i),
    .flush_i  (flush_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .valid_o  (valid_o),
    .busy_o   (busy_o)
  );

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b0; ctrl_i = 4'h0; data1_i = '0; data2_i = '0; flush_i = 1'b0;
    #12;
    n_total++;
    if (result_o !== 32'h0) $display("FAIL reset_result got %h want %h", result_o, 32'h0);
    else n_pass++;
    n_total++;
    if (zero_o !== 1'b1) $display("FAIL reset_zero got %b want 1", zero_o);
    else n_pass++;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o);
    else n_pass++;
  endtask

  // Reset release and first accept on the very first edge.
  task automatic test_first_add();
    @(negedge clk_i);
    rst_i = 1'b1; start_i = 1'b1; ctrl_i = 4'b0011; data1_i = 32'd5; data2_i = 32'd7;
    @(posedge clk_i); #1;
    n_total++;
    if (result_o !== 32'd12) $display("FAIL first_add_result got %h want %h", result_o, 32'd12);
    else n_pass++;
    n_total++;
    if (zero_o !== 1'b0) $display("FAIL first_add_zero got %b want 0", zero_o);
    else n_pass++;
    n_total++;
    if (valid_o !== 1'b1) $display("FAIL first_add_valid got %b want 1", valid_o);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0) $display("FAIL first_add_busy got %b want 0", busy_o);
    else n_pass++;
    @(negedge clk_i);
    start_i = 1'b0; data1_i = 32'hDEAD; data2_i = 32'hBEEF;
    @(posedge clk_i); #1;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL idle_valid got %b want 0", valid_o);
    else n_pass++;
    n_total++;
    if (result_o !== 32'd12) $display("FAIL idle_hold got %h want %h", result_o, 32'd12);
    else n_pass++;
  endtask

  // Back-to-back single-cycle ops with start held high.
  task automatic test_ops();
    logic [3:0]  c [14];
    logic [31:0] a [14];
    logic [31:0] b [14];
    logic [31:0] e [14];
    int n;
    c[0]  = 4'b0000; a[0]  = 32'hF0F0_1234; b[0]  = 32'h0FF0_FF00; e[0]  = 32'h00F0_1200;
    c[1]  = 4'b0001; a[1]  = 32'hFFFF_0000; b[1]  = 32'h0F0F_0F0F; e[1]  = 32'hF0F0_0F0F;
    c[2]  = 4'b0010; a[2]  = 32'h0000_0001; b[2]  = 32'h0000_0023; e[2]  = 32'h0000_0008;
    c[3]  = 4'b0011; a[3]  = 32'hFFFF_FFFF; b[3]  = 32'h0000_0001; e[3]  = 32'h0000_0000;
    c[4]  = 4'b0100; a[4]  = 32'd5;         b[4]  = 32'd7;         e[4]  = 32'hFFFF_FFFE;
    c[5]  = 4'b0110; a[5]  = 32'd100;       b[5]  = 32'd23;        e[5]  = 32'd123;
    c[6]  = 4'b0111; a[6]  = 32'h8000_0000; b[6]  = 32'd4;         e[6]  = 32'hF800_0000;
    c[7]  = 4'b1000; a[7]  = 32'h7FFF_FFFF; b[7]  = 32'd1;         e[7]  = 32'h8000_0000;
    c[8]  = 4'b1001; a[8]  = 32'h1234;      b[8]  = 32'h1234;      e[8]  = 32'h0;
    c[9]  = 4'b0111; a[9]  = 32'h4000_0000; b[9]  = 32'h0000_003E; e[9]  = 32'h0000_0001;
    c[10] = 4'b1010; a[10] = 32'h1111_1111; b[10] = 32'h2222_2222; e[10] = 32'h0;
    c[11] = 4'b0010; a[11] = 32'h0000_00FF; b[11] = 32'd8;         e[11] = 32'h0000_FF00;
    c[12] = 4'b1111; a[12] = 32'h1111_1111; b[12] = 32'h2222_2222; e[12] = 32'h0;
    c[13] = 4'b0101; a[13] = 32'd6;         b[13] = 32'd7;         e[13] = 32'h0;
`ifdef EX_ALU_MUL_EN
    n = 13;
`else
    n = 14;
`endif
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      start_i = 1'b1; ctrl_i = c[i]; data1_i = a[i]; data2_i = b[i];
      @(posedge clk_i); #1;
      n_total++;
      if (result_o !== e[i]) $display("FAIL op%0d_result got %h want %h", i, result_o, e[i]);
      else n_pass++;
      n_total++;
      if (zero_o !== (e[i] == 32'h0)) $display("FAIL op%0d_zero got %b want %b", i, zero_o,
                                              (e[i] == 32'h0));
      else n_pass++;
      n_total++;
      if (valid_o !== 1'b1) $display("FAIL op%0d_valid got %b want 1", i, valid_o);
      else n_pass++;
      n_total++;
      if (busy_o !== 1'b0) $display("FAIL op%0d_busy got %b want 0", i, busy_o);
      else n_pass++;
    end
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // flush_i with start_i in idle: nothing accepted, result unchanged.
  task automatic test_flush_idle();
    logic [31:0] prev;
    @(negedge clk_i);
    start_i = 1'b0; ctrl_i = 4'b0011; data1_i = 32'd40; data2_i = 32'd2;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    prev = 32'd42;
    @(negedge clk_i);
    flush_i = 1'b1; data1_i = 32'd1; data2_i = 32'd1;
    @(posedge clk_i); #1;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL flush_idle_valid got %b want 0", valid_o);
    else n_pass++;
    n_total++;
    if (result_o !== prev) $display("FAIL flush_idle_result got %h want %h", result_o, prev);
    else n_pass++;
    @(negedge clk_i);
    flush_i = 1'b0; start_i = 1'b0;
  endtask

`ifdef EX_ALU_MUL_EN
  task automatic test_mul();
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0101; data1_i = 32'hFFFF_FFFF; data2_i = 32'd3;
    @(posedge clk_i); #1;
    n_total++;
    if (busy_o !== 1'b1) $display("FAIL mul_accept_busy got %b want 1", busy_o);
    else n_pass++;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk_i);
      start_i = (k >= 5 && k < 9);
      ctrl_i  = (k >= 5) ? 4'b0011 : 4'b0101;
      data1_i = 32'h0000_1000 + k; data2_i = 32'h55;
      @(posedge clk_i); #1;
      n_total++;
      if (busy_o !== 1'b1 || valid_o !== 1'b0)
        $display("FAIL mul_cycle%0d busy/valid got %b/%b want 1/0", k, busy_o, valid_o);
      else n_pass++;
    end
    @(posedge clk_i); #1;
    n_total++;
    if (valid_o !== 1'b1) $display("FAIL mul_valid got %b want 1", valid_o);
    else n_pass++;
    n_total++;
    if (result_o !== 32'hFFFF_FFFD) $display("FAIL mul_result got %h want %h", result_o,
                                             32'hFFFF_FFFD);
    else n_pass++;
    n_total++;
    if (busy_o !== 1'b0 || zero_o !== 1'b0)
      $display("FAIL mul_done busy/zero got %b/%b want 0/0", busy_o, zero_o);
    else n_pass++;
  endtask

  task automatic test_mul_flush();
    logic seen;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0101; data1_i = 32'd6; data2_i = 32'd7;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (8) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    n_total++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0)
      $display("FAIL mul_flush busy/valid got %b/%b want 0/0", busy_o, valid_o);
    else n_pass++;
    n_total++;
    if (result_o !== 32'hFFFF_FFFD) $display("FAIL mul_flush_hold got %h want %h", result_o,
                                             32'hFFFF_FFFD);
    else n_pass++;
    @(negedge clk_i);
    flush_i = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (valid_o) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL mul_flush_late_valid got %b want 0", seen);
    else n_pass++;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0011; data1_i = 32'd2; data2_i = 32'd3;
    @(posedge clk_i); #1;
    n_total++;
    if (result_o !== 32'd5 || valid_o !== 1'b1)
      $display("FAIL post_flush_add got %h/%b want %h/1", result_o, valid_o, 32'd5);
    else n_pass++;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic test_mul_reset();
    logic seen;
    @(negedge clk_i);
    start_i = 1'b1; ctrl_i = 4'b0101; data1_i = 32'd6; data2_i = 32'd7;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    n_total++;
    if (result_o !== 32'h0 || zero_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL mul_reset got r=%h z=%b v=%b b=%b want r=0 z=1 v=0 b=0",
               result_o, zero_o, valid_o, busy_o);
    else n_pass++;
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o || busy_o) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL mul_reset_after got %b want 0", seen);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_add();
    test_ops();
    test_flush_idle();
`ifdef EX_ALU_MUL_EN
    test_mul();
    test_mul_flush();
    test_mul_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
